// File: rtl/img_cmd_engine.sv
// img_cmd_engine: opcode/data consumer with a byte line buffer, in-place point ops and
// byte-by-byte readback through a free/valid return handshake.
module img_cmd_engine #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        cmd_in,
  input  logic              cmd_valid,
  input  logic [7:0]        data_in,
  input  logic              data_valid,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_free,
  output logic              busy,
  output logic [ADDR_W:0]   len
);
  typedef enum logic [3:0] {
    IDLE, WRITE, THR_WAIT, RD_FETCH, RD_SEND, RD_GAP, RD_WAIT, PR_FETCH, PR_WR
  } state_t;
  localparam logic [ADDR_W:0]   FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] AONE = ADDR_W'(1);
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d, len_q, len_d, ptr_nx;
  logic [7:0]        thr_q, thr_d, out_data_q, out_data_d, ram_q, wdata;
  logic              out_valid_q, out_valid_d, inv_q, inv_d, we, cmd_ok;
  logic [ADDR_W-1:0] waddr;
  logic [7:0]        mem [DEPTH];
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign len       = len_q;
  assign busy      = !(state_q == IDLE || state_q == WRITE);
  assign ptr_nx    = rd_ptr_q + ONE;
  assign cmd_ok    = cmd_valid && !busy;
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    len_d       = len_q;
    thr_d       = thr_q;
    inv_d       = inv_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    we          = 1'b0;
    waddr       = wr_ptr_q;
    wdata       = data_in;
    if (state_q == WRITE && data_valid) begin
      we       = 1'b1;
      wr_ptr_d = wr_ptr_q + AONE;
      len_d    = (len_q == FULL) ? len_q : len_q + ONE;
    end
    case (state_q)
      THR_WAIT: if (data_valid) begin
        thr_d    = data_in;
        rd_ptr_d = '0;
        state_d  = (len_q == '0) ? IDLE : PR_FETCH;
      end
      RD_WAIT:  state_d = (rd_ptr_q >= len_q) ? IDLE : out_free ? RD_FETCH : RD_WAIT;
      RD_FETCH: begin
        // the byte is only launched if the return buffer is still free this cycle
        state_d     = out_free ? RD_SEND : RD_WAIT;
        out_valid_d = out_free;
        out_data_d  = out_free ? mem[rd_ptr_q[ADDR_W-1:0]] : out_data_q;
      end
      RD_SEND:  begin
        rd_ptr_d = ptr_nx;
        state_d  = RD_GAP;
      end
      RD_GAP:   state_d = RD_WAIT;
      PR_FETCH: state_d = PR_WR;
      PR_WR:    begin
        we       = 1'b1;
        waddr    = rd_ptr_q[ADDR_W-1:0];
        wdata    = inv_q ? ~ram_q : (ram_q >= thr_q) ? 8'hFF : 8'h00;
        rd_ptr_d = ptr_nx;
        state_d  = (ptr_nx >= len_q) ? IDLE : PR_FETCH;
      end
      default: ;
    endcase
    // an opcode arriving with a data byte acts after that byte is counted
    if (cmd_ok) begin
      case (cmd_in)
        8'h00: state_d = IDLE;
        8'h01: begin
          len_d    = '0;
          wr_ptr_d = '0;
          state_d  = IDLE;
        end
        8'h02: state_d = WRITE;
        8'h03: begin
          rd_ptr_d = '0;
          state_d  = RD_WAIT;
        end
        8'h04: begin
          inv_d    = 1'b1;
          rd_ptr_d = '0;
          state_d  = (len_d == '0) ? IDLE : PR_FETCH;
        end
        8'h05: begin
          inv_d   = 1'b0;
          state_d = THR_WAIT;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      len_q       <= '0;
      thr_q       <= '0;
      inv_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      len_q       <= len_d;
      thr_q       <= thr_d;
      inv_q       <= inv_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    ram_q <= mem[rd_ptr_q[ADDR_W-1:0]];
  end
endmodule

// File: tb/tb_img_cmd_engine.sv
// tb_img_cmd_engine: directed checks of a 256-byte and a 4-byte instance sharing one host driver.
module tb_img_cmd_engine;
  logic       clk = 1'b0, reset = 1'b1, sel = 1'b0, force_low = 1'b0;
  logic [7:0] cmd_in = '0, data_in = '0;
  logic       cmd_valid = 1'b0, data_valid = 1'b0;
  logic [7:0] out_data_b, out_data_s;
  logic       out_valid_b, out_valid_s, busy_b, busy_s, out_free;
  logic [8:0] len_b;
  logic [2:0] len_s;
  int         low_cnt = 0, n_cmp = 0, n_err = 0;
  logic [7:0] q_b[$], q_s[$];

  always #5 clk = ~clk;

  img_cmd_engine u_big (
    .clk(clk), .reset(reset), .cmd_in(cmd_in), .cmd_valid(cmd_valid & ~sel),
    .data_in(data_in), .data_valid(data_valid & ~sel), .out_data(out_data_b),
    .out_valid(out_valid_b), .out_free(out_free), .busy(busy_b), .len(len_b)
  );
  img_cmd_engine #(.DEPTH(4), .ADDR_W(2)) u_small (
    .clk(clk), .reset(reset), .cmd_in(cmd_in), .cmd_valid(cmd_valid & sel),
    .data_in(data_in), .data_valid(data_valid & sel), .out_data(out_data_s),
    .out_valid(out_valid_s), .out_free(out_free), .busy(busy_s), .len(len_s)
  );

  always @(posedge clk)
    low_cnt <= (out_valid_b | out_valid_s) ? 4 : (low_cnt > 0) ? low_cnt - 1 : 0;
  assign out_free = !force_low && low_cnt == 0;

  always @(negedge clk) begin
    if (out_valid_b) q_b.push_back(out_data_b);
    if (out_valid_s) q_s.push_back(out_data_s);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_cmd(input logic [7:0] op);
    cmd_in = op;
    cmd_valid = 1'b1;
    tick(1);
    cmd_valid = 1'b0;
  endtask

  task automatic send_data(input logic [7:0] d);
    data_in = d;
    data_valid = 1'b1;
    tick(1);
    data_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy_b || busy_s) && n < 2000) begin
      tick(1);
      n++;
    end
    check({tag, "_idle"}, {31'd0, busy_b | busy_s}, 0);
  endtask

  task automatic check_q(input string tag, input logic [7:0] e0, e1, e2, e3, input int n);
    logic [7:0] e[4];
    e = '{e0, e1, e2, e3};
    check({tag, "_cnt"}, q_b.size() + q_s.size(), n);
    for (int i = 0; i < n; i++)
      check($sformatf("%s_b%0d", tag, i), sel ? (i < q_s.size() ? q_s[i] : 8'hxx) : (i < q_b.size() ? q_b[i] : 8'hxx), e[i]);
  endtask

  initial begin
    int n;
    tick(3);
    check("rst_out_data", out_data_b, 0);
    check("rst_out_valid", out_valid_b, 0);
    check("rst_busy", busy_b, 0);
    check("rst_len", len_b, 0);
    reset = 1'b0;
    tick(1);

    send_cmd(8'h01); send_cmd(8'h02);
    send_data(8'h10); send_data(8'h20); send_data(8'h30);
    q_b.delete();
    send_cmd(8'h03);
    wait_idle("rd1");
    check_q("rd1", 8'h10, 8'h20, 8'h30, 8'h00, 3);
    check("rd1_len", len_b, 3);

    send_cmd(8'h01); send_cmd(8'h02);
    send_data(8'h00); send_data(8'h7F); send_data(8'hFF);
    send_cmd(8'h04);
    n = 0;
    while (busy_b && n < 100) begin
      tick(1);
      n++;
    end
    check("inv_busy_cycles", n, 6);
    q_b.delete();
    send_cmd(8'h03);
    wait_idle("rd2");
    check_q("rd2", 8'hFF, 8'h80, 8'h00, 8'h00, 3);

    send_cmd(8'h01); send_cmd(8'h02);
    send_data(8'h05); send_data(8'h80); send_data(8'h81);
    q_b.delete();
    send_cmd(8'h05);
    send_cmd(8'h03);
    check("thr_wait_busy", busy_b, 1);
    tick(10);
    check("thr_wait_no_out", q_b.size(), 0);
    send_data(8'h80);
    wait_idle("thr");
    check("thr_no_out", q_b.size(), 0);
    send_cmd(8'h03);
    wait_idle("rd3");
    check_q("rd3", 8'h00, 8'hFF, 8'hFF, 8'h00, 3);

    sel = 1'b1;
    send_cmd(8'h01); send_cmd(8'h02);
    for (int i = 1; i <= 6; i++) send_data(8'(i));
    check("small_len", len_s, 4);
    q_b.delete(); q_s.delete();
    send_cmd(8'h03);
    wait_idle("rd4");
    check_q("rd4", 8'h05, 8'h06, 8'h03, 8'h04, 4);
    sel = 1'b0;

    send_cmd(8'h01);
    q_b.delete(); q_s.delete();
    send_cmd(8'h03);
    n = 0;
    while (busy_b && n < 100) begin
      tick(1);
      n++;
    end
    check("rd0_busy_le1", {31'd0, n <= 1}, 1);
    check("rd0_no_out", q_b.size(), 0);
    send_cmd(8'h02); send_data(8'hAA); send_data(8'hBB);
    force_low = 1'b1;
    send_cmd(8'h03);
    tick(20);
    check("hold_no_out", q_b.size(), 0);
    check("hold_busy", busy_b, 1);
    force_low = 1'b0;
    wait_idle("rd5");
    check_q("rd5", 8'hAA, 8'hBB, 8'h00, 8'h00, 2);

    send_cmd(8'h01); send_cmd(8'h02);
    send_data(8'h11); send_data(8'h22); send_data(8'h33);
    q_b.delete();
    send_cmd(8'h03);
    n = 0;
    while (q_b.size() == 0 && n < 100) begin
      tick(1);
      n++;
    end
    check("mid_first", q_b.size(), 1);
    tick(1);
    reset = 1'b1;
    #1;
    check("mid_rst_valid", out_valid_b, 0);
    check("mid_rst_busy", busy_b, 0);
    check("mid_rst_len", len_b, 0);
    tick(2);
    reset = 1'b0;
    tick(1);
    send_cmd(8'h03);
    wait_idle("rd6");
    tick(5);
    check("post_rst_no_out", q_b.size(), 1);
    check("post_rst_len", len_b, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
